// File: rtl/hazard_pkg.sv
// Shared types and constants for the load-use / memory-wait hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_e;

  localparam logic [5:0] OPC_LW   = 6'b100011;
  localparam logic [5:0] OPC_XORI = 6'b001110;
  localparam int         CNT_W    = 2;

  // Remaining LU_STALL cycles after the zero-latency bubble issued from RUN.
  function automatic logic [CNT_W-1:0] lu_cnt_load(input int unsigned lu_cycles);
    logic [31:0] rem;
    rem = lu_cycles - 32'd1;
    return rem[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/hazard_reg_cmp.sv
// Register-address equality compare; a match against register zero never counts.
module hazard_reg_cmp #(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src_i,
  input  logic [REG_AW-1:0] dst_i,
  output logic              match_o
);

  assign match_o = (src_i == dst_i) && (dst_i != {REG_AW{1'b0}});

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Load-use / data-memory-wait hazard controller with branch-flush priority.
// Optional HAZARD_PERF_CNT_EN adds saturating stall-cycle performance counters.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int              REG_AW          = 5,
  parameter int              OP_W            = 6,
  parameter int              LOAD_USE_CYCLES = 1,
  parameter logic [OP_W-1:0] OPC_RT_DST0     = OPC_LW,
  parameter logic [OP_W-1:0] OPC_RT_DST1     = OPC_XORI
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [OP_W-1:0]   id_op,
  input  logic              mem_req,
  input  logic              mem_ready,
  input  logic              branch_taken,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0]       perf_lu_cycles,
  output logic [31:0]       perf_mem_cycles,
`endif
  output logic              pc_we,
  output logic              ifid_we,
  output logic              idex_flush,
  output logic              ifid_flush,
  output logic              pipe_hold,
  output logic              stall_busy
);

  localparam logic [CNT_W-1:0] LU_LOAD = lu_cnt_load(LOAD_USE_CYCLES);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ret_q, ret_d;

  logic rs_match_s, rt_match_s, rt_is_src_s, lu_haz_s, mem_wait_s;
  logic pc_we_s, ifid_we_s, idex_flush_s, ifid_flush_s, pipe_hold_s;

  hazard_reg_cmp #(.REG_AW(REG_AW)) u_cmp_rs (.src_i(id_rs), .dst_i(ex_rt), .match_o(rs_match_s));
  hazard_reg_cmp #(.REG_AW(REG_AW)) u_cmp_rt (.src_i(id_rt), .dst_i(ex_rt), .match_o(rt_match_s));

  assign rt_is_src_s = (id_op != OPC_RT_DST0) && (id_op != OPC_RT_DST1);
  assign lu_haz_s    = ex_mem_read && id_valid && (rs_match_s || (rt_match_s && rt_is_src_s));
  assign mem_wait_s  = mem_req && !mem_ready;

  // State, bubble counter and MEM_WAIT return flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= {CNT_W{1'b0}};
      ret_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ret_q   <= ret_d;
    end
  end

  // Next-state logic; MEM_WAIT ignores branches because EX is frozen.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ret_d   = ret_q;
    case (state_q)
      RUN: begin
        if (branch_taken) begin
          cnt_d = {CNT_W{1'b0}};
        end else if (mem_wait_s) begin
          state_d = MEM_WAIT;
          ret_d   = 1'b0;
        end else if (lu_haz_s && (LOAD_USE_CYCLES > 1)) begin
          state_d = LU_STALL;
          cnt_d   = LU_LOAD;
        end else begin
          state_d = RUN;
        end
      end
      LU_STALL: begin
        if (branch_taken) begin
          state_d = RUN;
          cnt_d   = {CNT_W{1'b0}};
        end else if (mem_wait_s) begin
          state_d = MEM_WAIT;
          ret_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_q <= {{(CNT_W-1){1'b0}}, 1'b1}) begin
            state_d = RUN;
          end else begin
            state_d = LU_STALL;
          end
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_d = ret_q ? LU_STALL : RUN;
          ret_d   = 1'b0;
        end else begin
          state_d = MEM_WAIT;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = {CNT_W{1'b0}};
        ret_d   = 1'b0;
      end
    endcase
  end

  // Output decode; reset forces the free-running pattern regardless of inputs.
  always_comb begin
    pc_we_s      = 1'b1;
    ifid_we_s    = 1'b1;
    idex_flush_s = 1'b0;
    ifid_flush_s = 1'b0;
    pipe_hold_s  = 1'b0;
    if (!rst_n) begin
      pc_we_s = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (branch_taken) begin
            ifid_flush_s = 1'b1;
            idex_flush_s = 1'b1;
          end else if (mem_wait_s) begin
            pc_we_s     = 1'b0;
            ifid_we_s   = 1'b0;
            pipe_hold_s = 1'b1;
          end else if (lu_haz_s) begin
            pc_we_s      = 1'b0;
            ifid_we_s    = 1'b0;
            idex_flush_s = 1'b1;
          end else begin
            pc_we_s = 1'b1;
          end
        end
        LU_STALL: begin
          if (branch_taken) begin
            ifid_flush_s = 1'b1;
            idex_flush_s = 1'b1;
          end else begin
            pc_we_s      = 1'b0;
            ifid_we_s    = 1'b0;
            idex_flush_s = 1'b1;
          end
        end
        MEM_WAIT: begin
          pc_we_s     = 1'b0;
          ifid_we_s   = 1'b0;
          pipe_hold_s = 1'b1;
        end
        default: begin
          pc_we_s = 1'b1;
        end
      endcase
    end
  end

  assign pc_we      = pc_we_s;
  assign ifid_we    = ifid_we_s;
  assign idex_flush = idex_flush_s;
  assign ifid_flush = ifid_flush_s;
  assign pipe_hold  = pipe_hold_s;
  assign stall_busy = rst_n && (state_q != RUN);

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_lu_q, perf_mem_q;
  logic        lu_pat_s;

  assign lu_pat_s = idex_flush_s && !ifid_flush_s;

  // Saturating counters of load-use stall and memory-hold cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_lu_q  <= 32'd0;
      perf_mem_q <= 32'd0;
    end else begin
      if (lu_pat_s && (perf_lu_q != 32'hFFFF_FFFF)) begin
        perf_lu_q <= perf_lu_q + 32'd1;
      end
      if (pipe_hold_s && (perf_mem_q != 32'hFFFF_FFFF)) begin
        perf_mem_q <= perf_mem_q + 32'd1;
      end
    end
  end

  assign perf_lu_cycles  = perf_lu_q;
  assign perf_mem_cycles = perf_mem_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: one DUT with a single bubble, one with three.
// Output vectors are {pc_we, ifid_we, idex_flush, ifid_flush, pipe_hold, stall_busy}.
module tb_hazard_stall_ctrl;

  localparam logic [5:0] P_RUN   = 6'b110000;
  localparam logic [5:0] P_STALL = 6'b001000;
  localparam logic [5:0] P_LUST  = 6'b001001;
  localparam logic [5:0] P_FLUSH = 6'b111100;
  localparam logic [5:0] P_FLBSY = 6'b111101;
  localparam logic [5:0] P_HOLD  = 6'b000010;
  localparam logic [5:0] P_MWAIT = 6'b000011;
  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_XORI = 6'b001110;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ex_mem_read, id_valid, mem_req, mem_ready, branch_taken;
  logic [4:0] ex_rt, id_rs, id_rt;
  logic [5:0] id_op;
  logic       pc_we1, ifid_we1, idex_flush1, ifid_flush1, pipe_hold1, stall_busy1;
  logic       pc_we3, ifid_we3, idex_flush3, ifid_flush3, pipe_hold3, stall_busy3;
  logic [5:0] d1, d3;
  int         n_pass = 0;
  int         n_total = 0;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] plu1, pmem1, plu3, pmem3;
`endif

  always #5 clk = ~clk;

  assign d1 = {pc_we1, ifid_we1, idex_flush1, ifid_flush1, pipe_hold1, stall_busy1};
  assign d3 = {pc_we3, ifid_we3, idex_flush3, ifid_flush3, pipe_hold3, stall_busy3};

  hazard_stall_ctrl #(.LOAD_USE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_op(id_op),
    .mem_req(mem_req), .mem_ready(mem_ready), .branch_taken(branch_taken),
`ifdef HAZARD_PERF_CNT_EN
    .perf_lu_cycles(plu1), .perf_mem_cycles(pmem1),
`endif
    .pc_we(pc_we1), .ifid_we(ifid_we1), .idex_flush(idex_flush1),
    .ifid_flush(ifid_flush1), .pipe_hold(pipe_hold1), .stall_busy(stall_busy1)
  );

  hazard_stall_ctrl #(.LOAD_USE_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_op(id_op),
    .mem_req(mem_req), .mem_ready(mem_ready), .branch_taken(branch_taken),
`ifdef HAZARD_PERF_CNT_EN
    .perf_lu_cycles(plu3), .perf_mem_cycles(pmem3),
`endif
    .pc_we(pc_we3), .ifid_we(ifid_we3), .idex_flush(idex_flush3),
    .ifid_flush(ifid_flush3), .pipe_hold(pipe_hold3), .stall_busy(stall_busy3)
  );

  task automatic set_in(input logic mr, input logic [4:0] ert, input logic v,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [5:0] op,
                        input logic mq, input logic mrdy, input logic br);
    ex_mem_read = mr; ex_rt = ert; id_valid = v; id_rs = rs; id_rt = rt; id_op = op;
    mem_req = mq; mem_ready = mrdy; branch_taken = br;
  endtask

  // One cycle: drive at the falling edge, outputs are checked 1 time unit later.
  task automatic cyc(input logic mr, input logic [4:0] ert, input logic v,
                     input logic [4:0] rs, input logic [4:0] rt, input logic [5:0] op,
                     input logic mq, input logic mrdy, input logic br);
    @(negedge clk);
    set_in(mr, ert, v, rs, rt, op, mq, mrdy, br);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, OP_ADD, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic haz();
    cyc(1'b1, 5'd5, 1'b1, 5'd5, 5'd0, OP_ADD, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    set_in(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, OP_ADD, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_in(1'b1, 5'd5, 1'b1, 5'd5, 5'd0, OP_ADD, 1'b0, 1'b0, 1'b0);
    #2;
    n_total++; if (d1 !== P_RUN) $display("FAIL reset_d1: got %b want %b", d1, P_RUN); else n_pass++;
    n_total++; if (d3 !== P_RUN) $display("FAIL reset_d3: got %b want %b", d3, P_RUN); else n_pass++;
    do_reset();
  endtask

  task automatic test_lu_single();
    do_reset();
    haz();
    n_total++; if (d1 !== P_STALL) $display("FAIL lu1_c0: got %b want %b", d1, P_STALL); else n_pass++;
    idle();
    n_total++; if (d1 !== P_RUN) $display("FAIL lu1_c1: got %b want %b", d1, P_RUN); else n_pass++;
  endtask

  task automatic test_rt_compare();
    do_reset();
    cyc(1'b1, 5'd5, 1'b1, 5'd7, 5'd5, OP_LW, 1'b0, 1'b0, 1'b0);
    n_total++; if (d1 !== P_RUN) $display("FAIL rt_lw: got %b want %b", d1, P_RUN); else n_pass++;
    cyc(1'b1, 5'd5, 1'b1, 5'd7, 5'd5, OP_XORI, 1'b0, 1'b0, 1'b0);
    n_total++; if (d1 !== P_RUN) $display("FAIL rt_xori: got %b want %b", d1, P_RUN); else n_pass++;
    cyc(1'b1, 5'd5, 1'b1, 5'd7, 5'd5, OP_ADD, 1'b0, 1'b0, 1'b0);
    n_total++; if (d1 !== P_STALL) $display("FAIL rt_add: got %b want %b", d1, P_STALL); else n_pass++;
    cyc(1'b1, 5'd0, 1'b1, 5'd0, 5'd0, OP_ADD, 1'b0, 1'b0, 1'b0);
    n_total++; if (d1 !== P_RUN) $display("FAIL r0_excl: got %b want %b", d1, P_RUN); else n_pass++;
    cyc(1'b1, 5'd5, 1'b0, 5'd5, 5'd5, OP_ADD, 1'b0, 1'b0, 1'b0);
    n_total++; if (d1 !== P_RUN) $display("FAIL id_invalid: got %b want %b", d1, P_RUN); else n_pass++;
  endtask

  task automatic test_multi_bubble();
    do_reset();
    haz();
    n_total++; if (d3 !== P_STALL) $display("FAIL lu3_c0: got %b want %b", d3, P_STALL); else n_pass++;
    idle();
    n_total++; if (d3 !== P_LUST) $display("FAIL lu3_c1: got %b want %b", d3, P_LUST); else n_pass++;
    n_total++; if (d1 !== P_RUN) $display("FAIL lu1_vs3_c1: got %b want %b", d1, P_RUN); else n_pass++;
    idle();
    n_total++; if (d3 !== P_LUST) $display("FAIL lu3_c2: got %b want %b", d3, P_LUST); else n_pass++;
    idle();
    n_total++; if (d3 !== P_RUN) $display("FAIL lu3_c3: got %b want %b", d3, P_RUN); else n_pass++;
  endtask

  task automatic test_mem_in_stall();
    do_reset();
    haz();
    idle();
    n_total++; if (d3 !== P_LUST) $display("FAIL mw_c1: got %b want %b", d3, P_LUST); else n_pass++;
    cyc(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, OP_ADD, 1'b1, 1'b0, 1'b0);
    n_total++; if (d3 !== P_LUST) $display("FAIL mw_enter3: got %b want %b", d3, P_LUST); else n_pass++;
    n_total++; if (d1 !== P_HOLD) $display("FAIL mw_enter1: got %b want %b", d1, P_HOLD); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, OP_ADD, 1'b1, 1'b0, 1'b0);
      n_total++; if (d3 !== P_MWAIT) $display("FAIL mw_hold%0d: got %b want %b", i, d3, P_MWAIT); else n_pass++;
    end
    cyc(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, OP_ADD, 1'b1, 1'b1, 1'b0);
    n_total++; if (d3 !== P_MWAIT) $display("FAIL mw_ready3: got %b want %b", d3, P_MWAIT); else n_pass++;
    n_total++; if (d1 !== P_MWAIT) $display("FAIL mw_ready1: got %b want %b", d1, P_MWAIT); else n_pass++;
    idle();
    n_total++; if (d3 !== P_LUST) $display("FAIL mw_resume: got %b want %b", d3, P_LUST); else n_pass++;
    n_total++; if (d1 !== P_RUN) $display("FAIL mw_exit1: got %b want %b", d1, P_RUN); else n_pass++;
    idle();
    n_total++; if (d3 !== P_RUN) $display("FAIL mw_done: got %b want %b", d3, P_RUN); else n_pass++;
`ifdef HAZARD_PERF_CNT_EN
    n_total++; if (plu3 !== 32'd4) $display("FAIL perf_lu3: got %0d want %0d", plu3, 4); else n_pass++;
    n_total++; if (pmem3 !== 32'd4) $display("FAIL perf_mem3: got %0d want %0d", pmem3, 4); else n_pass++;
    n_total++; if (plu1 !== 32'd1) $display("FAIL perf_lu1: got %0d want %0d", plu1, 1); else n_pass++;
    n_total++; if (pmem1 !== 32'd5) $display("FAIL perf_mem1: got %0d want %0d", pmem1, 5); else n_pass++;
`endif
  endtask

  task automatic test_branch();
    do_reset();
    cyc(1'b1, 5'd5, 1'b1, 5'd5, 5'd0, OP_ADD, 1'b0, 1'b0, 1'b1);
    n_total++; if (d1 !== P_FLUSH) $display("FAIL br_lu1: got %b want %b", d1, P_FLUSH); else n_pass++;
    n_total++; if (d3 !== P_FLUSH) $display("FAIL br_lu3: got %b want %b", d3, P_FLUSH); else n_pass++;
    idle();
    n_total++; if (d3 !== P_RUN) $display("FAIL br_stay_run: got %b want %b", d3, P_RUN); else n_pass++;
    haz();
    cyc(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, OP_ADD, 1'b0, 1'b0, 1'b1);
    n_total++; if (d3 !== P_FLBSY) $display("FAIL br_abort: got %b want %b", d3, P_FLBSY); else n_pass++;
    idle();
    n_total++; if (d3 !== P_RUN) $display("FAIL br_abort_run: got %b want %b", d3, P_RUN); else n_pass++;
    cyc(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, OP_ADD, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, OP_ADD, 1'b1, 1'b0, 1'b1);
    n_total++; if (d1 !== P_MWAIT) $display("FAIL br_in_mw: got %b want %b", d1, P_MWAIT); else n_pass++;
    cyc(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, OP_ADD, 1'b1, 1'b1, 1'b0);
    idle();
    n_total++; if (d1 !== P_RUN) $display("FAIL br_mw_exit: got %b want %b", d1, P_RUN); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    haz();
    idle();
    #1 rst_n = 1'b0;
    #1;
    n_total++; if (d3 !== P_RUN) $display("FAIL rst_mid_lu: got %b want %b", d3, P_RUN); else n_pass++;
`ifdef HAZARD_PERF_CNT_EN
    n_total++; if (plu3 !== 32'd0) $display("FAIL rst_perf_lu: got %0d want %0d", plu3, 0); else n_pass++;
`endif
    do_reset();
    cyc(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, OP_ADD, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, OP_ADD, 1'b1, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    n_total++; if (d1 !== P_RUN) $display("FAIL rst_mid_mw: got %b want %b", d1, P_RUN); else n_pass++;
`ifdef HAZARD_PERF_CNT_EN
    n_total++; if (pmem1 !== 32'd0) $display("FAIL rst_perf_mem: got %0d want %0d", pmem1, 0); else n_pass++;
`endif
    do_reset();
  endtask

  initial begin
    test_reset();
    test_lu_single();
    test_rt_compare();
    test_multi_bubble();
    test_mem_in_stall();
    test_branch();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
